// File: rtl/noc_buf_pkg.sv
// noc_buf_pkg
//   Shared helpers for the NoC router input buffer.
//   - clog2         : ceiling log2 of a positive integer (clog2(1) = 0)
//   - vc_width      : VC index width, at least 1 bit
//   - ptr_width     : per-VC pointer width, log2(DEPTH)
//   - cnt_width     : per-VC occupancy width, able to hold DEPTH itself
//   - FLIT_W_DEFAULT: default flit width
package noc_buf_pkg;

  localparam int FLIT_W_DEFAULT = 8;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int vc_width(input int num_vc);
    return (clog2(num_vc) < 1) ? 1 : clog2(num_vc);
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

  // One extra bit so that count == DEPTH can be represented.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// vc_fifo_lane
//   One virtual-channel circular FIFO. push and pop arrive already
//   qualified by the top level, so a push never targets a full lane and a
//   pop never targets an empty one.
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   synchronous reset, active high
//     push_i       in   accepted write into this lane
//     pop_i        in   accepted read from this lane
//     wr_data_i    in   flit to store on push
//     rd_data_o    out  head flit, combinational (mem[rptr])
//     empty_o      out  count == 0
//     full_o       out  count == DEPTH
//     almost_ful_o out  count >= AF_LEVEL
//     count_o      out  current occupancy
module vc_fifo_lane
  import noc_buf_pkg::*;
#(
  parameter int NUM_BITS = FLIT_W_DEFAULT,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  localparam int PW      = ptr_width(DEPTH),
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [NUM_BITS-1:0] wr_data_i,
  output logic [NUM_BITS-1:0] rd_data_o,
  output logic                empty_o,
  output logic                full_o,
  output logic                almost_full_o,
  output logic [CW-1:0]       count_o
);

  logic [NUM_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;

  // Pointers wrap through natural PW-bit overflow (DEPTH is a power of 2).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PW'(1);
    if (pop_i)  rptr_d = rptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (push_i && !rst_n) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o     = mem_q[rptr_q];
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CW'(DEPTH));
  assign almost_full_o = (count_q >= CW'(AF_LEVEL));
  assign count_o       = count_q;

endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer
//   Multi-VC input buffer for a NoC router input port: NUM_VC independent
//   FIFOs behind one write port and one read port, each steered by a VC id.
//   Ports:
//     clk          in   clock, rising edge
//     rst_n        in   synchronous reset, active high
//     wr_en        in   write request
//     wr_vc        in   target VC of the write
//     wr_data      in   flit to write
//     rd_en        in   read request
//     rd_vc        in   source VC of the read
//     rd_data      out  registered read data, holds when no read accepted
//     rd_valid     out  high the cycle after an accepted read
//     empty        out  per-VC empty flag
//     full         out  per-VC full flag
//     almost_full  out  per-VC count >= AF_LEVEL
//     count        out  per-VC occupancy, VC i at [i*CW +: CW]
//     wr_err       out  one-cycle pulse on a rejected write
//     rd_err       out  one-cycle pulse on a rejected read
module vc_input_buffer
  import noc_buf_pkg::*;
#(
  parameter int NUM_BITS = FLIT_W_DEFAULT,
  parameter int DEPTH    = 8,
  parameter int NUM_VC   = 2,
  parameter int AF_LEVEL = 6,
  localparam int VCW     = vc_width(NUM_VC),
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [NUM_BITS-1:0]  wr_data,
  input  logic                 rd_en,
  input  logic [VCW-1:0]       rd_vc,
  output logic [NUM_BITS-1:0]  rd_data,
  output logic                 rd_valid,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] count,
  output logic                 wr_err,
  output logic                 rd_err
);

  logic [NUM_VC-1:0]   push, pop;
  logic [NUM_BITS-1:0] lane_rdata [NUM_VC];
  logic [NUM_BITS-1:0] sel_rdata;
  logic                wr_acc, rd_acc;

  logic [NUM_BITS-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, wr_err_q, rd_err_q;

  // VC decode. An index >= NUM_VC matches no lane, so it is rejected with
  // no state change. Flags are the pre-edge ones: no same-cycle bypass.
  always_comb begin
    push      = '0;
    pop       = '0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (wr_en && (int'(wr_vc) == i) && !full[i]) push[i] = 1'b1;
      if (rd_en && (int'(rd_vc) == i) && !empty[i]) begin
        pop[i]    = 1'b1;
        sel_rdata = lane_rdata[i];
      end
    end
  end

  assign wr_acc    = |push;
  assign rd_acc    = |pop;
  assign rd_data_d = rd_acc ? sel_rdata : rd_data_q;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
    vc_fifo_lane #(
      .NUM_BITS (NUM_BITS),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .push_i        (push[g]),
      .pop_i         (pop[g]),
      .wr_data_i     (wr_data),
      .rd_data_o     (lane_rdata[g]),
      .empty_o       (empty[g]),
      .full_o        (full[g]),
      .almost_full_o (almost_full[g]),
      .count_o       (count[g*CW +: CW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_acc;
      wr_err_q   <= wr_en && !wr_acc;
      rd_err_q   <= rd_en && !rd_acc;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;

  localparam int NB  = 8;
  localparam int DP  = 4;
  localparam int NV  = 2;
  localparam int AF  = 3;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [0:0]    wr_vc;
  logic [NB-1:0] wr_data;
  logic          rd_en;
  logic [0:0]    rd_vc;
  logic [NB-1:0] rd_data;
  logic          rd_valid;
  logic [NV-1:0] empty, full, almost_full;
  logic [NV*CW-1:0] count;
  logic          wr_err, rd_err;

  int n_applied = 0;
  int n_miss    = 0;

  always #5 clk = ~clk;

  vc_input_buffer #(
    .NUM_BITS (NB),
    .DEPTH    (DP),
    .NUM_VC   (NV),
    .AF_LEVEL (AF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_vc       (wr_vc),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_vc       (rd_vc),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .wr_err      (wr_err),
    .rd_err      (rd_err)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic       wvc;
    logic [7:0] wd;
    logic       re;
    logic       rvc;
    int         c0;
    int         c1;
    logic       rv;
    logic [7:0] rd;
    logic       werr;
    logic       rerr;
  } tv_t;

  tv_t vecs[$];

  function automatic tv_t mk(input logic rst, input logic we, input logic wvc,
                             input logic [7:0] wd, input logic re, input logic rvc,
                             input int c0, input int c1, input logic rv,
                             input logic [7:0] rd, input logic werr, input logic rerr);
    tv_t t;
    t.rst = rst; t.we = we; t.wvc = wvc; t.wd = wd; t.re = re; t.rvc = rvc;
    t.c0 = c0; t.c1 = c1; t.rv = rv; t.rd = rd; t.werr = werr; t.rerr = rerr;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic wvc,
                       input logic [7:0] wd, input logic re, input logic rvc);
    rst_n = rst; wr_en = we; wr_vc = wvc; wr_data = wd; rd_en = re; rd_vc = rvc;
    @(posedge clk);
    #1;
  endtask

  // Flags follow from the expected counts.
  task automatic chk_state(input int idx, input int c0, input int c1);
    logic [1:0] e_empty, e_full, e_af;
    e_empty = {c1 == 0, c0 == 0};
    e_full  = {c1 == DP, c0 == DP};
    e_af    = {c1 >= AF, c0 >= AF};
    chk("count0", idx, 32'(count[0 +: CW]), 32'(c0));
    chk("count1", idx, 32'(count[CW +: CW]), 32'(c1));
    chk("empty", idx, 32'(empty), 32'(e_empty));
    chk("full", idx, 32'(full), 32'(e_full));
    chk("almost_full", idx, 32'(almost_full), 32'(e_af));
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_vc = 1'b0; wr_data = '0; rd_en = 1'b0; rd_vc = 1'b0;

    //                rst we vc wd    re vc  c0 c1 rv rd     werr rerr
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 0, 0)); // 1 idle
    vecs.push_back(mk(0, 1, 1, 8'h11, 0, 0,  0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h22, 0, 0,  0, 2, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h33, 0, 0,  0, 3, 0, 8'h00, 0, 0)); // af[1]
    vecs.push_back(mk(0, 1, 1, 8'h44, 0, 0,  0, 4, 0, 8'h00, 0, 0)); // full[1]
    vecs.push_back(mk(0, 1, 1, 8'h55, 0, 0,  0, 4, 0, 8'h00, 1, 0)); // overflow
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 3, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 2, 1, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 1, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 0, 1, 8'h44, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h44, 0, 0)); // 11 hold
    vecs.push_back(mk(0, 1, 0, 8'hA0, 0, 0,  1, 0, 0, 8'h44, 0, 0)); // isolation
    vecs.push_back(mk(0, 1, 1, 8'hB0, 0, 0,  1, 1, 0, 8'h44, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  1, 0, 1, 8'hB0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0,  0, 0, 1, 8'hA0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h01, 0, 0,  1, 0, 0, 8'hA0, 0, 0)); // fill VC0
    vecs.push_back(mk(0, 1, 0, 8'h02, 0, 0,  2, 0, 0, 8'hA0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h03, 0, 0,  3, 0, 0, 8'hA0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h04, 0, 0,  4, 0, 0, 8'hA0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h05, 1, 0,  3, 0, 1, 8'h01, 1, 0)); // 20 full r+w
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0,  2, 0, 1, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h06, 1, 0,  2, 0, 1, 8'h03, 0, 0)); // r+w at 2
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0,  1, 0, 1, 8'h04, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0,  0, 0, 1, 8'h06, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h7E, 1, 0,  1, 0, 0, 8'h06, 0, 1)); // 25 empty r+w
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0,  0, 0, 1, 8'h7E, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 0, 0, 8'h7E, 0, 1)); // empty VC1
    vecs.push_back(mk(0, 1, 0, 8'hC1, 0, 0,  1, 0, 0, 8'h7E, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'hD1, 1, 0,  0, 1, 1, 8'hC1, 0, 0)); // diff VCs
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1,  0, 0, 1, 8'hD1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].wvc, vecs[i].wd, vecs[i].re, vecs[i].rvc);
      chk_state(i, vecs[i].c0, vecs[i].c1);
      chk("rd_valid", i, 32'(rd_valid), 32'(vecs[i].rv));
      chk("rd_data", i, 32'(rd_data), 32'(vecs[i].rd));
      chk("wr_err", i, 32'(wr_err), 32'(vecs[i].werr));
      chk("rd_err", i, 32'(rd_err), 32'(vecs[i].rerr));
    end

    // Ten write/read pairs on VC1 so both pointers wrap more than once.
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      d = 8'h60 + 8'(k);
      drive(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0);
      chk("wrap_count_w", 100 + k, 32'(count[CW +: CW]), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("wrap_data", 100 + k, 32'(rd_data), 32'(d));
      chk("wrap_valid", 100 + k, 32'(rd_valid), 32'd1);
      chk("wrap_count_r", 100 + k, 32'(count[CW +: CW]), 32'd0);
    end

    // Reset in the middle of a burst, with a write in flight.
    drive(1'b0, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'hE2, 1'b1, 1'b1);
    chk_state(200, 1, 0);
    chk("burst_rd", 200, 32'(rd_data), 32'hE1);
    drive(1'b1, 1'b1, 1'b1, 8'hE3, 1'b0, 1'b0);
    chk_state(201, 0, 0);
    chk("rst_rd_data", 201, 32'(rd_data), 32'h0);
    chk("rst_rd_valid", 201, 32'(rd_valid), 32'h0);
    chk("rst_wr_err", 201, 32'(wr_err), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_state(202, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk_state(203, 0, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("post_rst_rd", 204, 32'(rd_data), 32'h99);
    chk("post_rst_valid", 204, 32'(rd_valid), 32'h1);
    chk_state(204, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
